// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares the 4:1 mux between four requesters.
// Ports: clk, rst_n (async low) | req[3:0], done | gnt[3:0], s0, s1, busy, timeout.
// Optional hold-time watchdog enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 ||
      MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_param
    $error("mux4_rr_arbiter: illegal MAX_HOLD/CNT_W");
  end

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] pick;
  logic       pick_vld;
  logic       rel;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  // Search starts just after the last owner, so it ends up lowest.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_vld && req[ptr_q + 2'(i)]) begin
        pick_vld = 1'b1;
        pick     = ptr_q + 2'(i);
      end
    end
  end

  assign rel = done | ~req[sel_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          ptr_d   = pick;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign s0   = sel_q[0];
  assign s1   = sel_q[1];
  assign busy = (state_q == GRANT);

endmodule
